vc_pop_arbiter: RTL and testbench

Sequences the two virtual-channel FIFOs (VC0, VC1) toward the shared output mux: owns the init/idle/active/error state machine, programs the almost-full/almost-empty thresholds into both FIFOs, and decides each cycle which FIFO (if any) is popped. VC0 has priority over VC1, an optional fairness window prevents VC1 starvation, and downstream pause from the D0/D1 FIFOs stalls all pops. Sits between the VC FIFO pair and the VC-to-D mux.

---
 rtl/vc_arb_pkg.sv | 47 ++++
 rtl/vc_burst_counter.sv | 32 +++
 rtl/vc_pop_arbiter.sv | 101 ++++++++++
 tb/tb_vc_pop_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vc_arb_pkg.sv
// Shared types and constants for the VC pop arbiter.
package vc_arb_pkg;

  localparam int unsigned THR_W = 4;

  // Threshold values held in the output registers while reset is applied
  localparam logic [THR_W-1:0] AF_RST = 4'hF;
  localparam logic [THR_W-1:0] AE_RST = 4'h0;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } arb_state_t;

  // Next arbiter state; a FIFO error pre-empts everything except leaving RESET
  function automatic arb_state_t next_state(input arb_state_t cur,
                                            input logic init,
                                            input logic err,
                                            input logic any_data);
    arb_state_t nxt;
    nxt = cur;
    if (cur == ST_RESET) begin
      nxt = ST_INIT;
    end else if (err) begin
      nxt = ST_ERROR;
    end else begin
      case (cur)
        ST_INIT:   nxt = init ? ST_INIT : ST_IDLE;
        ST_IDLE: begin
          if (init)          nxt = ST_INIT;
          else if (any_data) nxt = ST_ACTIVE;
        end
        ST_ACTIVE: begin
          // both FIFOs empty implies no pop can be in progress this cycle
          if (init)           nxt = ST_INIT;
          else if (!any_data) nxt = ST_IDLE;
        end
        default:   nxt = ST_ERROR;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/vc_burst_counter.sv
// Counts consecutive VC0 grants and forces one VC1 slot after BURST_MAX of them.
module vc_burst_counter #(
  parameter int unsigned BURST_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic empty_vc0,
  input  logic empty_vc1,
  input  logic grant_vc0,
  input  logic grant_vc1,
  output logic force_vc1_c
);

  localparam int unsigned CNT_W = $clog2(BURST_MAX + 1);

  logic [CNT_W-1:0] cnt;

  // Force VC1 only when it actually has a word to give
  assign force_vc1_c = (cnt == CNT_W'(BURST_MAX)) && !empty_vc1;

  // Saturating run counter; cleared when VC1 is served or VC0 has drained
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (grant_vc1 || empty_vc0) begin
      cnt <= '0;
    end else if (grant_vc0 && (cnt != CNT_W'(BURST_MAX))) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/vc_pop_arbiter.sv
// Pop arbiter for the VC0/VC1 FIFO pair feeding the VC-to-D mux.
// Define ARB_FAIRNESS_EN to compile in the BURST_MAX fairness window;
// without it VC0 has strict priority over VC1.
module vc_pop_arbiter
  import vc_arb_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 6,
  parameter int unsigned THR_W     = 4,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic [THR_W-1:0] afVC_in,
  input  logic [THR_W-1:0] aeVC_in,
  input  logic             fifo_empty_vc0,
  input  logic             fifo_empty_vc1,
  input  logic             fifo_error_vc0,
  input  logic             fifo_error_vc1,
  input  logic             pause_d0,
  input  logic             pause_d1,
  output logic [THR_W-1:0] afVC_o,
  output logic [THR_W-1:0] aeVC_o,
  output logic             pop_vc0,
  output logic             pop_vc1,
  output logic             sel_mux,
  output logic             valid_out,
  output logic             active_out,
  output logic             idle_out,
  output logic             error_out
);

  arb_state_t state;
  arb_state_t nxt_c;
  logic       err_c;
  logic       stall_c;
  logic       any_data_c;
  logic       pop_ok_c;
  logic       force_vc1_c;

  // DATA_SIZE only documents the FIFO word width; BURST_MAX is idle in the strict build
  logic unused_params;
  assign unused_params = |(32'(DATA_SIZE) ^ 32'(BURST_MAX));

  assign err_c      = fifo_error_vc0 | fifo_error_vc1;
  assign stall_c    = pause_d0 | pause_d1;
  assign any_data_c = !fifo_empty_vc0 || !fifo_empty_vc1;
  assign nxt_c      = next_state(state, init, err_c, any_data_c);

  // Pops only in a settled ACTIVE cycle: not leaving for INIT/ERROR, no downstream pause
  assign pop_ok_c = !reset && (state == ST_ACTIVE) && !err_c && !init && !stall_c;

`ifdef ARB_FAIRNESS_EN
  vc_burst_counter #(
    .BURST_MAX (BURST_MAX)
  ) u_burst (
    .clk         (clk),
    .reset       (reset),
    .empty_vc0   (fifo_empty_vc0),
    .empty_vc1   (fifo_empty_vc1),
    .grant_vc0   (pop_vc0),
    .grant_vc1   (pop_vc1),
    .force_vc1_c (force_vc1_c)
  );
`else
  assign force_vc1_c = 1'b0;
`endif

  // Zero-cycle grant: VC0 first unless the fairness window hands the slot to VC1
  assign pop_vc0 = pop_ok_c && !fifo_empty_vc0 && !force_vc1_c;
  assign pop_vc1 = pop_ok_c && !fifo_empty_vc1 && (fifo_empty_vc0 || force_vc1_c);

  // State register, thresholds, state indicators and read-data alignment
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_RESET;
      afVC_o     <= THR_W'(AF_RST);
      aeVC_o     <= THR_W'(AE_RST);
      valid_out  <= 1'b0;
      sel_mux    <= 1'b0;
      active_out <= 1'b0;
      idle_out   <= 1'b0;
      error_out  <= 1'b0;
    end else begin
      state      <= nxt_c;
      active_out <= (nxt_c == ST_ACTIVE);
      idle_out   <= (nxt_c == ST_IDLE);
      error_out  <= (nxt_c == ST_ERROR);
      if ((state == ST_INIT) && init) begin
        afVC_o <= afVC_in;
        aeVC_o <= aeVC_in;
      end
      // RAM read latency is one cycle, so the mux follows the pop by one clock
      valid_out <= pop_vc0 | pop_vc1;
      if (pop_vc0 | pop_vc1) begin
        sel_mux <= pop_vc1;
      end
    end
  end

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// Randomised + directed bench for vc_pop_arbiter against a behavioural model.
module tb_vc_pop_arbiter;

  localparam int unsigned THR_W     = 4;
  localparam int unsigned BURST_MAX = 4;
  localparam int M_RESET  = 0;
  localparam int M_INIT   = 1;
  localparam int M_IDLE   = 2;
  localparam int M_ACTIVE = 3;
  localparam int M_ERROR  = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             init;
  logic [THR_W-1:0] afVC_in;
  logic [THR_W-1:0] aeVC_in;
  logic             fifo_empty_vc0;
  logic             fifo_empty_vc1;
  logic             fifo_error_vc0;
  logic             fifo_error_vc1;
  logic             pause_d0;
  logic             pause_d1;
  logic [THR_W-1:0] afVC_o;
  logic [THR_W-1:0] aeVC_o;
  logic             pop_vc0;
  logic             pop_vc1;
  logic             sel_mux;
  logic             valid_out;
  logic             active_out;
  logic             idle_out;
  logic             error_out;

  vc_pop_arbiter #(
    .DATA_SIZE (6),
    .THR_W     (THR_W),
    .BURST_MAX (BURST_MAX)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .init           (init),
    .afVC_in        (afVC_in),
    .aeVC_in        (aeVC_in),
    .fifo_empty_vc0 (fifo_empty_vc0),
    .fifo_empty_vc1 (fifo_empty_vc1),
    .fifo_error_vc0 (fifo_error_vc0),
    .fifo_error_vc1 (fifo_error_vc1),
    .pause_d0       (pause_d0),
    .pause_d1       (pause_d1),
    .afVC_o         (afVC_o),
    .aeVC_o         (aeVC_o),
    .pop_vc0        (pop_vc0),
    .pop_vc1        (pop_vc1),
    .sel_mux        (sel_mux),
    .valid_out      (valid_out),
    .active_out     (active_out),
    .idle_out       (idle_out),
    .error_out      (error_out)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Words currently held in each FIFO (the bench plays the FIFO pair)
  int cnt0 = 0;
  int cnt1 = 0;

  // Behavioural model
  int         m_state = M_RESET;
  logic [3:0] m_af    = 4'hF;
  logic [3:0] m_ae    = 4'h0;
  bit         m_valid = 1'b0;
  bit         m_sel   = 1'b0;
  int         m_run   = 0;   // consecutive VC0 grants since VC1 was last served

  bit grants[$];             // DUT pop_vc1 value for every observed pop

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void exp_pops(output bit p0, output bit p1);
    bit ok;
    bit fvc1;
    ok   = !reset && (m_state == M_ACTIVE) && !fifo_error_vc0 && !fifo_error_vc1
           && !init && !pause_d0 && !pause_d1;
    fvc1 = 1'b0;
`ifdef ARB_FAIRNESS_EN
    fvc1 = (m_run >= int'(BURST_MAX)) && (cnt1 > 0);
`endif
    p1 = ok && (cnt1 > 0) && ((cnt0 == 0) || fvc1);
    p0 = ok && (cnt0 > 0) && !fvc1;
  endfunction

  task automatic advance(input bit p0, input bit p1);
    bit err;
    bit data;
    if (reset) begin
      m_state = M_RESET; m_af = 4'hF; m_ae = 4'h0;
      m_valid = 1'b0; m_sel = 1'b0; m_run = 0;
    end else begin
      err  = fifo_error_vc0 || fifo_error_vc1;
      data = (cnt0 > 0) || (cnt1 > 0);
      m_valid = p0 || p1;
      if (p0 || p1) m_sel = p1;
      if ((m_state == M_INIT) && init) begin
        m_af = afVC_in;
        m_ae = aeVC_in;
      end
      if (p1 || (cnt0 == 0))                     m_run = 0;
      else if (p0 && (m_run < int'(BURST_MAX))) m_run++;
      if (p0) cnt0--;
      if (p1) cnt1--;
      if (m_state == M_RESET)  m_state = M_INIT;
      else if (err)            m_state = M_ERROR;
      else if (m_state == M_INIT)   m_state = init ? M_INIT : M_IDLE;
      else if (m_state == M_IDLE)   m_state = init ? M_INIT : (data ? M_ACTIVE : M_IDLE);
      else if (m_state == M_ACTIVE) m_state = init ? M_INIT : (data ? M_ACTIVE : M_IDLE);
    end
  endtask

  // One clock: drive inputs, compare at the falling edge, step the model at the rising edge
  task automatic tick(input bit rst, input bit ini, input logic [3:0] af, input logic [3:0] ae,
                      input int add0, input int add1, input bit pd0, input bit pd1,
                      input bit er0, input bit er1);
    bit p0;
    bit p1;
    reset = rst; init = ini; afVC_in = af; aeVC_in = ae;
    pause_d0 = pd0; pause_d1 = pd1;
    fifo_error_vc0 = er0; fifo_error_vc1 = er1;
    cnt0 += add0;
    cnt1 += add1;
    fifo_empty_vc0 = (cnt0 == 0);
    fifo_empty_vc1 = (cnt1 == 0);
    @(negedge clk);
    exp_pops(p0, p1);
    check("pop_vc0",    8'(pop_vc0),    8'(p0));
    check("pop_vc1",    8'(pop_vc1),    8'(p1));
    check("valid_out",  8'(valid_out),  8'(m_valid));
    check("sel_mux",    8'(sel_mux),    8'(m_sel));
    check("afVC_o",     8'(afVC_o),     8'(m_af));
    check("aeVC_o",     8'(aeVC_o),     8'(m_ae));
    check("active_out", 8'(active_out), 8'(m_state == M_ACTIVE));
    check("idle_out",   8'(idle_out),   8'(m_state == M_IDLE));
    check("error_out",  8'(error_out),  8'(m_state == M_ERROR));
    if (pop_vc0 || pop_vc1) grants.push_back(pop_vc1);
    @(posedge clk);
    advance(p0, p1);
    #1;
  endtask

  task automatic idle_tick(input bit ini);
    tick(1'b0, ini, 4'h0, 4'h0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
`ifdef ARB_FAIRNESS_EN
    bit exp_pat[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`else
    bit exp_pat[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
`endif
    bit seen_valid;
    reset = 1'b1; init = 1'b0; afVC_in = 4'h0; aeVC_in = 4'h0;
    fifo_empty_vc0 = 1'b1; fifo_empty_vc1 = 1'b1;
    fifo_error_vc0 = 1'b0; fifo_error_vc1 = 1'b0;
    pause_d0 = 1'b0; pause_d1 = 1'b0;
    @(posedge clk);
    #1;

    // Reset, then load thresholds A/2
    repeat (3) tick(1'b1, 1'b0, 4'h0, 4'h0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_af_literal", 8'(afVC_o), 8'h0F);
    check("rst_ae_literal", 8'(aeVC_o), 8'h00);
    repeat (2) tick(1'b0, 1'b1, 4'hA, 4'h2, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_tick(1'b0);
    check("init_af_literal", 8'(afVC_o), 8'h0A);
    check("init_ae_literal", 8'(aeVC_o), 8'h02);
    check("init_idle_literal", 8'(idle_out), 8'h01);

    // VC0 alone with three words
    grants.delete();
    tick(1'b0, 1'b0, 4'h0, 4'h0, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) idle_tick(1'b0);
    check("vc0_only_count", 8'(grants.size()), 8'd3);
    foreach (grants[i]) check("vc0_only_chan", 8'(grants[i]), 8'd0);
    check("vc0_only_idle", 8'(idle_out), 8'h01);

    // Both channels loaded: priority / fairness grant pattern
    grants.delete();
    tick(1'b0, 1'b0, 4'h0, 4'h0, 8, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (13) idle_tick(1'b0);
    check("pattern_count", 8'(grants.size()), 8'd10);
    if (grants.size() == 10) begin
      foreach (exp_pat[i]) check("pattern_slot", 8'(grants[i]), 8'(exp_pat[i]));
    end

    // Downstream pause for two cycles mid-burst
    grants.delete();
    tick(1'b0, 1'b0, 4'h0, 4'h0, 6, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_tick(1'b0);
    repeat (2) tick(1'b0, 1'b0, 4'h0, 4'h0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (7) idle_tick(1'b0);
    check("pause_count", 8'(grants.size()), 8'd6);

    // Error pulse while active: sticky until reset
    tick(1'b0, 1'b0, 4'h0, 4'h0, 5, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_tick(1'b0);
    tick(1'b0, 1'b0, 4'h0, 4'h0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) idle_tick(1'b0);
    check("error_sticky_literal", 8'(error_out), 8'h01);

    // Reset while a word is in flight
    repeat (2) tick(1'b1, 1'b0, 4'h0, 4'h0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    seen_valid = 1'b0;
    for (int i = 0; i < 10 && !seen_valid; i++) begin
      idle_tick(1'b0);
      seen_valid = valid_out;
    end
    check("valid_reached", 8'(seen_valid), 8'h01);
    tick(1'b1, 1'b0, 4'h0, 4'h0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_valid_literal", 8'(valid_out), 8'h00);
    check("rst_af2_literal", 8'(afVC_o), 8'h0F);
    check("rst_active_literal", 8'(active_out), 8'h00);

    // Randomised traffic
    for (int n = 0; n < 1500; n++) begin
      bit rst;
      rst = ($urandom_range(0, 149) == 0) || ((m_state == M_ERROR) && ($urandom_range(0, 3) == 0));
      tick(rst,
           $urandom_range(0, 39) == 0,
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0,
           ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 299) == 0, $urandom_range(0, 299) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
